// File: rtl/key_conditioner_pkg.sv
// key_conditioner_pkg: shared stopwatch key-conditioning defaults, counter widths and event type
package key_conditioner_pkg;
  localparam int SAMPLE_DIV_DEF     = 1250000;
  localparam int STABLE_SAMPLES_DEF = 3;
  localparam int LONG_SAMPLES_DEF   = 80;
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  localparam int TICK_W_DEF  = cw(SAMPLE_DIV_DEF);
  localparam int AGREE_W_DEF = cw(STABLE_SAMPLES_DEF + 1);
  localparam int HOLD_W_DEF  = cw(LONG_SAMPLES_DEF + 1);
  typedef struct packed {
    logic press;
    logic press_nxt;
    logic down;
  } key_evt_t;
endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: synchronize, debounce and edge-detect one active-low pushbutton
module key_debounce_channel
  import key_conditioner_pkg::*;
#(
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     key_n,
  input  logic     tick,
  output key_evt_t evt
);
  localparam int AW = cw(STABLE_SAMPLES + 1);
  logic          sync1_q, sync2_q, stable_q, armed_q, press_q, down_q;
  logic          stable_d, armed_d, press_d, down_d;
  logic [1:0]    rdy_q, rdy_d;
  logic [AW-1:0] agree_q, agree_d;
  logic          diff, flip, rise;
  // armed_q blocks a press from a key that was already down when reset was released
  always_comb begin
    diff     = sync2_q != stable_q;
    flip     = tick && diff && (agree_q == AW'(STABLE_SAMPLES - 1));
    rise     = flip && !stable_q;
    agree_d  = !tick ? agree_q : (!diff || flip) ? '0 : agree_q + 1'b1;
    stable_d = stable_q ^ flip;
    press_d  = flip && stable_q && armed_q;
    armed_d  = armed_q || rise || (tick && rdy_q[1] && !diff && stable_q);
    down_d   = press_d || (down_q && !rise);
    rdy_d    = {rdy_q[0], 1'b1};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      rdy_q    <= '0;
      agree_q  <= '0;
      stable_q <= 1'b1;
      armed_q  <= 1'b0;
      press_q  <= 1'b0;
      down_q   <= 1'b0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      rdy_q    <= rdy_d;
      agree_q  <= agree_d;
      stable_q <= stable_d;
      armed_q  <= armed_d;
      press_q  <= press_d;
      down_q   <= down_d;
    end
  assign evt = '{press: press_q, press_nxt: press_d, down: down_q};
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: debounced start/pause and display keys driving run/freeze levels and strobes
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int SAMPLE_DIV     = SAMPLE_DIV_DEF,
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF,
  parameter int LONG_SAMPLES   = LONG_SAMPLES_DEF
) (
  input  logic CLOCK_50,
  input  logic key_reset,
  input  logic key_start_pause,
  input  logic key_display_stop,
  output logic run,
  output logic freeze,
  output logic start_pulse,
  output logic display_pulse,
  output logic clear_pulse,
  output logic sample_tick
);
  localparam int TW = cw(SAMPLE_DIV);
  localparam int HW = cw(LONG_SAMPLES + 1);
  key_evt_t      sp, dp;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          clear_q, clear_d, run_q, run_d, freeze_q, freeze_d;
  logic          unused_dp_down;
  key_debounce_channel #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_start (
    .clk(CLOCK_50), .rst_n(key_reset), .key_n(key_start_pause), .tick(sample_tick), .evt(sp)
  );
  key_debounce_channel #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_display (
    .clk(CLOCK_50), .rst_n(key_reset), .key_n(key_display_stop), .tick(sample_tick), .evt(dp)
  );
  // hold only counts presses that were accepted, so a key held through reset never clears
  always_comb begin
    sample_tick = cnt_q == TW'(SAMPLE_DIV - 1);
    cnt_d       = sample_tick ? '0 : cnt_q + 1'b1;
    clear_d     = sp.down && sample_tick && (hold_q == HW'(LONG_SAMPLES - 1));
    hold_d      = !sp.down ? '0 : (sample_tick && hold_q != HW'(LONG_SAMPLES)) ? hold_q + 1'b1 : hold_q;
    run_d       = !clear_d && (run_q ^ sp.press_nxt);
    freeze_d    = !clear_d && (freeze_q ^ dp.press_nxt);
  end
  always_ff @(posedge CLOCK_50 or negedge key_reset)
    if (!key_reset) begin
      cnt_q    <= '0;
      hold_q   <= '0;
      clear_q  <= 1'b0;
      run_q    <= 1'b0;
      freeze_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      clear_q  <= clear_d;
      run_q    <= run_d;
      freeze_q <= freeze_d;
    end
  assign unused_dp_down = dp.down;
  assign run            = run_q;
  assign freeze         = freeze_q;
  assign start_pulse    = sp.press;
  assign display_pulse  = dp.press;
  assign clear_pulse    = clear_q;
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The parameter SAMPLE_DIV SHALL default to 1250000 and sets the CLOCK_50 cycles per debounce sample tick (25 ms).
REQ-002 The parameter STABLE_SAMPLES SHALL default to 3 and sets the consecutive agreeing ticks needed to accept a key level change.
REQ-003 The parameter LONG_SAMPLES SHALL default to 80 and sets the ticks a start/pause key must be held low to count as a long press (2 s).
REQ-004 The port CLOCK_50 SHALL be an input, 1 bit, the sole clock, 50 MHz.
REQ-005 The port key_reset SHALL be an input, 1 bit, asynchronous active-low reset.
REQ-006 The port key_start_pause SHALL be an input, 1 bit, raw pushbutton, active-low, asynchronous to CLOCK_50.
REQ-007 The port key_display_stop SHALL be an input, 1 bit, raw pushbutton, active-low, asynchronous to CLOCK_50.
REQ-008 The port run SHALL be an output, 1 bit, level: stopwatch counting enabled.
REQ-009 The port freeze SHALL be an output, 1 bit, level: display held.
REQ-010 The port start_pulse SHALL be an output, 1 bit, one-cycle strobe per accepted start/pause press.
REQ-011 The port display_pulse SHALL be an output, 1 bit, one-cycle strobe per accepted display press.
REQ-012 The port clear_pulse SHALL be an output, 1 bit, one-cycle strobe per long press of start/pause.
REQ-013 The port sample_tick SHALL be an output, 1 bit, one-cycle strobe every SAMPLE_DIV cycles.

Function
REQ-014 Each raw key SHALL pass through a 2-flop synchronizer, and both flops SHALL reset to 1 (released).
REQ-015 The tick counter SHALL count 0..SAMPLE_DIV-1, assert sample_tick in the cycle it equals SAMPLE_DIV-1, and then wrap to 0.
REQ-016 Per key, a stable level register (reset 1) and an agree counter SHALL be kept, and both SHALL update only on sample_tick.
REQ-017 On a tick where the synchronized level differs from stable, the agree counter SHALL increment; when it reaches STABLE_SAMPLES, stable SHALL flip and the counter SHALL clear in that same cycle.
REQ-018 On a tick where the synchronized level equals stable, the agree counter SHALL clear, so bounce restarts qualification.
REQ-019 A stable 1->0 transition SHALL produce the corresponding press pulse in the next cycle, for exactly one cycle.
REQ-020 A stable 0->1 transition (release) SHALL produce no pulse.
REQ-021 run SHALL toggle on start_pulse and freeze SHALL toggle on display_pulse, each taking effect in the same cycle the pulse is high.
REQ-022 A hold counter SHALL clear when start/pause stable is 1, and SHALL increment on each tick while stable is 0, saturating at LONG_SAMPLES.
REQ-023 clear_pulse SHALL assert for one cycle when the hold counter first reaches LONG_SAMPLES, and only once per hold.
REQ-024 clear_pulse SHALL force run=0 and freeze=0 in its cycle, overriding any simultaneous display_pulse toggle.
REQ-025 The two keys SHALL be conditioned independently, and simultaneous presses SHALL yield both pulses in the same cycle.
REQ-026 Worst-case press latency SHALL be 2 + STABLE_SAMPLES*SAMPLE_DIV + 1 cycles after the input settles.

Reset
REQ-027 While key_reset is low, every register SHALL hold its reset value: run=0, freeze=0, all pulses 0, sample_tick=0, counters 0, stable=1.
REQ-028 Reset deassertion mid-press SHALL require full re-qualification, and no pulse SHALL emit for a key already held at release of reset until it is released and pressed again.

Structure
REQ-029 Parameter defaults and counter widths ($clog2 of SAMPLE_DIV, STABLE_SAMPLES+1, LONG_SAMPLES+1) SHALL live in the shared stopwatch package.
REQ-030 One sub-module, key_debounce_channel, SHALL contain the synchronizer, the agree counter, the stable register and press-pulse generation, and SHALL be instantiated twice.
REQ-031 The tick counter, hold counter and run/freeze toggles SHALL reside in the top-level module.

Verification
The following scenarios use SAMPLE_DIV=4, STABLE_SAMPLES=3 and LONG_SAMPLES=8.
REQ-032 Clean press: start/pause low at cycle 10 -> start_pulse exactly once at or before cycle 25, and run=1.
REQ-033 Bounce: start/pause toggled low/high every 3 cycles for 20 cycles, then held high -> no start_pulse, run unchanged.
REQ-034 Long hold: start/pause held low 40 cycles with run=1, freeze=1 -> start_pulse once (run 1->0), clear_pulse once, run=0, freeze=0, no further pulses until release.
REQ-035 Simultaneous: both keys pressed in the same cycle -> start_pulse and display_pulse in the same cycle, run=1, freeze=1.
REQ-036 Reset mid-press: key_reset low for 5 cycles while display key is low, then released with the key still low -> no display_pulse; release then press again -> one display_pulse.
REQ-037 Tick: free run 100 cycles -> sample_tick high exactly 25 cycles, spaced 4 apart.
